// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 max pooling over raster-ordered kernel images.
// One pooled value per window; pooling_done releases the upstream buffer.
module max_pool_stream #(
    parameter int BitSize    = 32,
    parameter int ImageWidth = 4,
    parameter int NumberOfK  = 4,
    localparam int KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic               clk,
    input  logic               res,
    input  logic               in_valid,
    input  logic [BitSize-1:0] in_data,
    output logic               out_valid,
    output logic [BitSize-1:0] out_data,
    output logic [KW-1:0]      out_kernel,
    output logic               out_last,
    output logic               pooling_done,
    output logic               overrun
);

    localparam int CW   = $clog2(ImageWidth);
    localparam int HALF = ImageWidth / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {FILL, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      row_q, row_d;
    logic [KW-1:0]      kernel_q, kernel_d;
    logic [BitSize-1:0] hold_q, hold_d;
    logic [BitSize-1:0] lb_q [HALF];
    logic [BitSize-1:0] lb_d [HALF];
    logic               out_valid_q, out_valid_d;
    logic [BitSize-1:0] out_data_q, out_data_d;
    logic [KW-1:0]      out_kernel_q, out_kernel_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic [HW-1:0]      hidx;

    function automatic logic [BitSize-1:0] smax(
        input logic [BitSize-1:0] a,
        input logic [BitSize-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign hidx = HW'(col_q >> 1);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        kernel_d     = kernel_q;
        hold_d       = hold_q;
        lb_d         = lb_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_kernel_d = out_kernel_q;
        out_last_d   = 1'b0;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (!col_q[0]) begin
                        hold_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_d[hidx] = smax(hold_q, in_data);
                    end else begin
                        out_data_d   = smax(smax(hold_q, in_data), lb_q[hidx]);
                        out_valid_d  = 1'b1;
                        out_kernel_d = kernel_q;
                    end
                    if (col_q == CW'(ImageWidth - 1)) begin
                        col_d = '0;
                        if (row_q == CW'(ImageWidth - 1)) begin
                            // Last pixel: the final window and done leave together.
                            row_d      = '0;
                            state_d    = FLUSH;
                            done_d     = 1'b1;
                            out_last_d = (kernel_q == KW'(NumberOfK - 1));
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                state_d = FILL;
                if (kernel_q == KW'(NumberOfK - 1)) begin
                    kernel_d = '0;
                end else begin
                    kernel_d = kernel_q + KW'(1);
                end
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            kernel_q     <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_kernel_q <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            kernel_q     <= kernel_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_kernel_q <= out_kernel_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_kernel   = out_kernel_q;
    assign out_last     = out_last_q;
    assign pooling_done = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench for max_pool_stream: a 4x4/2-kernel 32-bit instance
// and a 2x2/1-kernel 8-bit instance.
module tb_max_pool_stream;

    typedef struct {
        int     data;
        int     kern;
        bit     last;
        bit     done;
        longint cyc;
    } exp_t;

    logic        clk = 0;
    logic        res = 1;
    logic        iv_a = 0;
    logic [31:0] id_a = '0;
    logic        ov_a, last_a, done_a, orun_a;
    logic [31:0] od_a;
    logic [0:0]  ok_a;
    logic        iv_b = 0;
    logic [7:0]  id_b = '0;
    logic        ov_b, last_b, done_b, orun_b;
    logic [7:0]  od_b;
    logic [0:0]  ok_b;

    exp_t   q_a[$];
    exp_t   q_b[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     kern_a = 0;

    max_pool_stream #(.BitSize(32), .ImageWidth(4), .NumberOfK(2)) dut_a (
        .clk(clk), .res(res), .in_valid(iv_a), .in_data(id_a),
        .out_valid(ov_a), .out_data(od_a), .out_kernel(ok_a),
        .out_last(last_a), .pooling_done(done_a), .overrun(orun_a)
    );

    max_pool_stream #(.BitSize(8), .ImageWidth(2), .NumberOfK(1)) dut_b (
        .clk(clk), .res(res), .in_valid(iv_b), .in_data(id_b),
        .out_valid(ov_b), .out_data(od_b), .out_kernel(ok_b),
        .out_last(last_b), .pooling_done(done_b), .overrun(orun_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever an instance presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (ov_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected got data %0d expected nothing", $signed(od_a));
            end else begin
                e = q_a.pop_front();
                if ($signed(od_a) != e.data || int'(ok_a) != e.kern ||
                    last_a != e.last || done_a != e.done || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL a_out got d=%0d k=%0d l=%0b p=%0b c=%0d expected d=%0d k=%0d l=%0b p=%0b c=%0d",
                             $signed(od_a), ok_a, last_a, done_a, cyc,
                             e.data, e.kern, e.last, e.done, e.cyc);
                end
            end
        end else if (done_a || last_a) begin
            checks++;
            errors++;
            $display("FAIL a_stray_done got done=%0b last=%0b expected 0 without out_valid", done_a, last_a);
        end
        if (ov_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected got data %0d expected nothing", $signed(od_b));
            end else begin
                e = q_b.pop_front();
                if (int'($signed(od_b)) != e.data || int'(ok_b) != e.kern ||
                    last_b != e.last || done_b != e.done || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL b_out got d=%0d k=%0d l=%0b p=%0b c=%0d expected d=%0d k=%0d l=%0b p=%0b c=%0d",
                             $signed(od_b), ok_b, last_b, done_b, cyc,
                             e.data, e.kern, e.last, e.done, e.cyc);
                end
            end
        end
    end

    task automatic feed_a(input int pix[16], input int ex[4], input int n,
                          input int gap, input bit ovr);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iv_a = 1;
            id_a = pix[i];
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                q_a.push_back('{ex[k], kern_a, (i == 15) && (kern_a == 1),
                                i == 15, cyc + 1});
                k++;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                iv_a = 0;
            end
        end
        @(negedge clk);
        iv_a = ovr;
        id_a = 999;
        if (ovr) begin
            @(negedge clk);
            iv_a = 0;
        end
        if (n == 16) kern_a = 1 - kern_a;
    endtask

    task automatic feed_b(input int p0, input int p1, input int p2,
                          input int p3, input int ex);
        int pix[4] = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv_b = 1;
            id_b = 8'(pix[i]);
            if (i == 3) q_b.push_back('{ex, 0, 1'b1, 1'b1, cyc + 1});
        end
        @(negedge clk);
        iv_b = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int asc[16], hi[16], sgn[16];
        int e_asc[4] = '{5, 7, 13, 15};
        int e_hi[4]  = '{105, 107, 113, 115};
        int e_sgn[4] = '{-1, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            asc[i] = i;
            hi[i]  = 100 + i;
            sgn[i] = 0;
        end
        sgn[0] = -8; sgn[1] = -3; sgn[4] = -5; sgn[5] = -1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_pooling_done", done_a, 0);
        chk("rst_overrun", orun_a, 0);
        res = 0;

        feed_a(asc, e_asc, 16, 0, 0);
        feed_a(hi, e_hi, 16, 0, 0);
        feed_a(sgn, e_sgn, 16, 0, 0);
        feed_a(asc, e_asc, 16, 3, 0);
        chk("overrun_before", orun_a, 0);
        feed_a(asc, e_asc, 16, 0, 1);
        chk("overrun_set", orun_a, 1);
        feed_a(asc, e_asc, 16, 0, 0);
        chk("overrun_sticky", orun_a, 1);

        feed_a(asc, e_asc, 6, 0, 0);
        #2 res = 1;
        #1;
        chk("async_out_valid", ov_a, 0);
        chk("async_out_data", od_a, 0);
        chk("async_out_kernel", ok_a, 0);
        chk("async_out_last", last_a, 0);
        chk("async_done", done_a, 0);
        chk("async_overrun", orun_a, 0);
        kern_a = 0;
        @(negedge clk);
        res = 0;
        feed_a(asc, e_asc, 16, 0, 0);

        feed_b(3, 9, -2, 4, 9);
        feed_b(-128, -128, -128, -128, -128);
        feed_b(-7, -100, 5, -1, 5);

        repeat (5) @(negedge clk);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        chk("b_overrun", orun_b, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
